// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - iterative left-shift normalizer (unsigned / signed), one shift per cycle.
// Optional fast path for a zero operand: SHIFT_NORMALIZER_ZERO_DETECT_EN.
module shift_normalizer #(
  parameter int MAX_SHIFT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic [3:0]  shAmt,
  output logic        zero
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] work;
  logic [3:0]  cnt;
  logic        mode_q;
  logic        norm;
  logic        stop;

  // Signed values are normalized once the sign bit differs from the bit below it.
  assign norm = mode_q ? (work[15] ^ work[14]) : work[15];

`ifdef SHIFT_NORMALIZER_ZERO_DETECT_EN
  logic zero_q;
  logic zero_r;
  assign stop = norm || (cnt == MAX_CNT) || zero_q;
  assign zero = zero_r;
`else
  assign stop = norm || (cnt == MAX_CNT);
  assign zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (stop) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Results are captured on the way into DONE so they are valid with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= 16'h0000;
      cnt    <= 4'd0;
      mode_q <= 1'b0;
      out    <= 16'h0000;
      shAmt  <= 4'd0;
`ifdef SHIFT_NORMALIZER_ZERO_DETECT_EN
      zero_q <= 1'b0;
      zero_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work   <= a;
            mode_q <= mode;
            cnt    <= 4'd0;
`ifdef SHIFT_NORMALIZER_ZERO_DETECT_EN
            zero_q <= (a == 16'h0000);
`endif
          end
        end
        SHIFT: begin
          if (stop) begin
            out   <= work;
            shAmt <= cnt;
`ifdef SHIFT_NORMALIZER_ZERO_DETECT_EN
            zero_r <= zero_q;
`endif
          end else begin
            work <= {work[14:0], 1'b0};
            cnt  <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// tb/tb_shift_normalizer.sv - directed self-checking bench for shift_normalizer.
// Zero-operand expectations follow SHIFT_NORMALIZER_ZERO_DETECT_EN.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        mode = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [3:0]  shAmt;
  logic        zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_normalizer #(.MAX_SHIFT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .mode(mode),
    .busy(busy), .done(done), .out(out), .shAmt(shAmt), .zero(zero)
  );

  // Issue one request and return the cycle (edges after issue) at which done is seen.
  task automatic run_op(input logic [15:0] av, input logic mv, output int cyc);
    @(posedge clk); #1;
    start = 1'b1; a = av; mode = mv;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] av, input logic mv,
                          input int exp_cyc, input logic [15:0] exp_out,
                          input logic [3:0] exp_sh, input logic exp_zero);
    int cyc;
    run_op(av, mv, cyc);
    tests++;
    if (cyc !== exp_cyc) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cyc);
    end
    tests++;
    if (out !== exp_out || shAmt !== exp_sh || zero !== exp_zero) begin
      fails++;
      $display("FAIL %s result: got out=%h sh=%0d zero=%b expected out=%h sh=%0d zero=%b",
               name, out, shAmt, zero, exp_out, exp_sh, exp_zero);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL %s after-done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000 || shAmt !== 4'd0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL reset: got busy=%b done=%b out=%h sh=%0d zero=%b expected all 0",
               busy, done, out, shAmt, zero);
    end
  endtask

  task automatic test_unsigned();
    check_op("u_0001", 16'h0001, 1'b0, 17, 16'h8000, 4'd15, 1'b0);
    check_op("u_8000", 16'h8000, 1'b0, 2, 16'h8000, 4'd0, 1'b0);
    check_op("u_0123", 16'h0123, 1'b0, 9, 16'h9180, 4'd7, 1'b0);
  endtask

  task automatic test_signed();
    check_op("s_F000", 16'hF000, 1'b1, 5, 16'h8000, 4'd3, 1'b0);
    check_op("s_0300", 16'h0300, 1'b1, 7, 16'h6000, 4'd5, 1'b0);
    tests++;
    if (($signed(out) >>> shAmt) !== 16'sh0300) begin
      fails++; $display("FAIL s_0300 inverse: got %h expected 0300", $signed(out) >>> shAmt);
    end
    check_op("s_FFFF", 16'hFFFF, 1'b1, 17, 16'h8000, 4'd15, 1'b0);
    check_op("s_4000", 16'h4000, 1'b1, 2, 16'h4000, 4'd0, 1'b0);
  endtask

  task automatic test_zero();
`ifdef SHIFT_NORMALIZER_ZERO_DETECT_EN
    check_op("zero", 16'h0000, 1'b0, 2, 16'h0000, 4'd0, 1'b1);
`else
    check_op("zero", 16'h0000, 1'b0, 17, 16'h0000, 4'd15, 1'b0);
`endif
  endtask

  task automatic test_hold();
    logic [15:0] o;
    logic [3:0]  s;
    o = out; s = shAmt;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (out !== o || shAmt !== s) begin
      fails++; $display("FAIL hold: got out=%h sh=%0d expected out=%h sh=%0d", out, shAmt, o, s);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int first = -1;
    logic busy_after = 1'b1;
    logic [3:0] sh_at_done = 4'd0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0001; mode = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == first + 1 && first > 0) busy_after = busy;
      start = (c == 3);
      if (c == 3) a = 16'h8000;
      if (done) begin
        dones++;
        if (first < 0) begin
          first = c; sh_at_done = shAmt;
          start = 1'b1; a = 16'h8000;
        end
      end
    end
    start = 1'b0;
    tests++;
    if (dones !== 1 || first !== 17 || sh_at_done !== 4'd15) begin
      fails++;
      $display("FAIL back_to_back: got dones=%0d cycle=%0d sh=%0d expected 1 17 15",
               dones, first, sh_at_done);
    end
    tests++;
    if (busy_after !== 1'b0) begin
      fails++; $display("FAIL start_in_done: got busy=%b expected 0", busy_after);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(posedge clk); #1;
    start = 1'b1; a = 16'h0001; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    tests++;
    if (busy !== 1'b0 || out !== 16'h0000 || shAmt !== 4'd0) begin
      fails++; $display("FAIL abort: got busy=%b out=%h sh=%0d expected 0 0000 0", busy, out, shAmt);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
    end
    check_op("post_abort", 16'h0C00, 1'b0, 6, 16'hC000, 4'd4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 SHALL have parameter MAX_SHIFT, default 15, giving the maximum left-shift count (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to normalize a.
REQ-005 SHALL have port a, input, 16, operand; sampled only when start is accepted.
REQ-006 SHALL have port mode, input, 1: 0 = unsigned, normalize to bit15=1; 1 = signed, normalize to bit15!=bit14. Sampled with a.
REQ-007 SHALL have port busy, output, 1, high in SHIFT and DONE states.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port out, output, 16, normalized value.
REQ-010 SHALL have port shAmt, output, 4, left shifts applied.
REQ-011 SHALL have port zero, output, 1, operand was 0x0000 (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 SHALL load a into the working register, latch mode, clear the count, and go to SHIFT. start=0 SHALL remain in IDLE.
REQ-014 SHIFT: each cycle SHALL test the register. If normalized per mode, or count==MAX_SHIFT, go to DONE. Otherwise shift the register left 1 with zero fill and increment count.
REQ-015 DONE: done SHALL be 1 for exactly this cycle. out and shAmt SHALL be updated. The FSM SHALL return to IDLE.
REQ-016 Latency: for k shifts, start at edge T SHALL give done=1 in the cycle after edge T+k+2; minimum 2 cycles, maximum MAX_SHIFT+2 cycles.
REQ-017 start while busy=1 SHALL be ignored, with no queuing. start in the DONE cycle SHALL also be ignored.
REQ-018 out, shAmt and zero SHALL hold their values from DONE until the next DONE.
REQ-019 The inverse property SHALL hold: a logical right shift (unsigned) or arithmetic right shift (signed) of out by shAmt SHALL equal a, whenever the loop ended on the normalized condition.
REQ-020 Signed 0xFFFF never normalizes. It SHALL terminate at MAX_SHIFT with out=0x8000 and shAmt=15 (default parameter).
REQ-021 shAmt SHALL never exceed MAX_SHIFT. The count SHALL not wrap.

Reset
REQ-022 rst=1 SHALL force IDLE and set busy=0, done=0, out=0x0000, shAmt=0, zero=0, and clear the working register and count, on the next edge.
REQ-023 rst asserted during SHIFT or DONE SHALL abort the operation with no done pulse. rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 Macro SHIFT_NORMALIZER_ZERO_DETECT_EN, when defined: an accepted start with a==0x0000 SHALL skip iteration. done SHALL pulse 2 cycles after start with zero=1, out=0x0000, shAmt=0.
REQ-025 Without SHIFT_NORMALIZER_ZERO_DETECT_EN: zero SHALL be tied 0. A 0x0000 operand SHALL iterate to MAX_SHIFT, giving out=0x0000 and shAmt=MAX_SHIFT.

Verification
REQ-026 mode=0, a=0x0001 -> done 17 cycles after start, out=0x8000, shAmt=15.
REQ-027 mode=0, a=0x8000 -> done 2 cycles after start, out=0x8000, shAmt=0. mode=1, a=0xF000 -> out=0x8000, shAmt=3.
REQ-028 mode=1, a=0x0300 -> out=0x6000, shAmt=5. Arithmetic right shift of 0x6000 by 5 gives 0x0300.
REQ-029 a=0x0000 with macro -> done at cycle 2, zero=1, shAmt=0, out=0. Without macro -> done at cycle 17, zero=0, shAmt=15, out=0.
REQ-030 Start a=0x0001, then pulse start with a=0x8000 at cycle 3 -> second request ignored; single done at cycle 17 with shAmt=15.
REQ-031 Start a=0x0001, assert rst at cycle 5 -> busy=0 next cycle, no done pulse, out=0x0000, shAmt=0. A new start then completes normally.
